pcie_logica_master: RTL and testbench
=====================================

Name: pcie_logica_master

Overview:
- Control/scheduling block for the PCIe transaction datapath: main FIFO (MF) -> VC0/VC1 FIFOs -> D0/D1 output FIFOs.
- Holds the datapath's threshold ("umbral") configuration, latched during an init window.
- Sequences the datapath through RESET/INIT/IDLE/ACTIVE/ERROR and drives active_out, idle_out and error_out.
- Arbitrates pops from MF and from VC0/VC1 with flow control from the downstream almost-full flags.

Parameters:
- MF_UW, 2, width of the MF threshold.
- VC_UW, 4, width of the VC0/VC1 thresholds.
- D_UW, 2, width of the D0/D1 thresholds.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  high = load thresholds / restart.
- umbral_MF_in  in  MF_UW  MF threshold to load.
- umbral_VC0_in  in  VC_UW  VC0 threshold to load.
- umbral_VC1_in  in  VC_UW  VC1 threshold to load.
- umbral_D0_in  in  D_UW  D0 threshold to load.
- umbral_D1_in  in  D_UW  D1 threshold to load.
- fifo_empty  in  5  empty flags {D1,D0,VC1,VC0,MF}, bit0 = MF.
- fifo_error  in  5  overflow/underflow flags, same bit order.
- almost_full  in  4  {D1,D0,VC1,VC0}.
- umbral_MF  out  MF_UW  registered MF threshold to the datapath.
- umbral_VC0  out  VC_UW  registered VC0 threshold.
- umbral_VC1  out  VC_UW  registered VC1 threshold.
- umbral_D0  out  D_UW  registered D0 threshold.
- umbral_D1  out  D_UW  registered D1 threshold.
- pop_MF  out  1  pop main FIFO.
- pop_VC0  out  1  pop VC0.
- pop_VC1  out  1  pop VC1.
- active_out  out  1  state == ACTIVE.
- idle_out  out  1  state == IDLE.
- error_out  out  1  state == ERROR.
- error_src  out  5  sticky record of the fifo_error bits that caused ERROR.

Behaviour:
- Reset (reset_L=0, asynchronous): state=RESET; all umbral_* = 0; error_src = 0; all outputs 0.
- State encoding (3 bits): RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Transitions are evaluated each rising edge with priority error > init > empty tests:
  - RESET -> INIT on the first edge after reset_L goes high, unconditionally.
  - INIT:
    - Load all five umbral_* registers from the *_in inputs every cycle.
    - Stay in INIT while init=1; go to IDLE when init=0.
    - fifo_error is ignored here; error_src is cleared on every INIT cycle.
  - IDLE:
    - Any fifo_error bit -> ERROR, with error_src <= fifo_error.
    - Else init=1 -> INIT.
    - Else any fifo_empty bit = 0 -> ACTIVE.
    - Else stay.
  - ACTIVE:
    - Any fifo_error bit -> ERROR, with error_src <= fifo_error.
    - Else init=1 -> INIT.
    - Else fifo_empty == 5'b11111 -> IDLE.
    - Else stay.
  - ERROR:
    - Sticky; error_src holds.
    - Only init=1 exits, to INIT.
- Status outputs are a combinational decode of the state register: exactly one of idle/active/error is high in IDLE, ACTIVE or ERROR; all three are 0 in RESET and INIT. They change the same edge the state changes.
- umbral_* change only in INIT. They hold through IDLE, ACTIVE and ERROR, and mid-operation re-init.
- Arbiter (combinational, gated by state==ACTIVE; all pops 0 in any other state):
  - pop_MF = !fifo_empty[0] & !almost_full[0] & !almost_full[1].
  - pop_VC0 = !fifo_empty[1] & !almost_full[2] & !almost_full[3].
  - pop_VC1 = !fifo_empty[2] & !almost_full[2] & !almost_full[3] & !pop_VC0. VC0 has strict priority; VC1 pops only in cycles VC0 does not.
  - pop_VC0 and pop_VC1 are never high together.
- Simultaneous error and init in IDLE/ACTIVE: ERROR wins. The next cycle with init=1 moves to INIT.
- Reset asserted in any state returns immediately to RESET, with thresholds lost.

Decomposition:
- Shared package:
  - state encoding localparams (RESET..ERROR);
  - FIFO index constants (MF=0, VC0=1, VC1=2, D0=3, D1=4);
  - default threshold widths.
- One natural sub-module: pcie_vc_arbiter, holding the combinational pop/priority logic. The FSM and threshold registers stay in the top.

Test Plan:
- Reset then init: reset_L=0 for 2 cycles, then 1 with init=1 and umbral_VC0_in=4'hA. -> state INIT; umbral_VC0=4'hA one edge later; all status outputs 0.
- Traffic start: drop init, set fifo_empty=5'b11110. -> IDLE for 1 cycle, then ACTIVE; active_out=1; pop_MF=1 when almost_full=0.
- Priority/backpressure (ACTIVE):
  - fifo_empty=5'b11000, almost_full=0 -> pop_VC0=1, pop_VC1=0.
  - Set fifo_empty[1]=1 -> pop_VC1=1.
  - Set almost_full[3]=1 -> both pops 0.
- Drain: fifo_empty=5'b11111 in ACTIVE. -> IDLE next edge; idle_out=1; all pops 0.
- Error sticky: fifo_error=5'b00100 in ACTIVE. -> ERROR; error_src=5'b00100 held after fifo_error=0. init=1 -> INIT, error_src=0, thresholds reloaded.
- Async reset mid-ACTIVE: reset_L low between edges. -> outputs and umbral_* = 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/pcie_logica_master_pkg.sv
// pcie_logica_master_pkg: shared state encoding, FIFO indices and threshold widths
package pcie_logica_master_pkg;
  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;
  localparam int MF_IDX  = 0;
  localparam int VC0_IDX = 1;
  localparam int VC1_IDX = 2;
  localparam int D0_IDX  = 3;
  localparam int D1_IDX  = 4;
  localparam int DEF_MF_UW = 2;
  localparam int DEF_VC_UW = 4;
  localparam int DEF_D_UW  = 2;
endpackage

// File: rtl/pcie_logica_master_if.sv
// pcie_logica_master_if: datapath config, FIFO status and pop bundle
interface pcie_logica_master_if
  import pcie_logica_master_pkg::*;
#(
  parameter int MF_UW = DEF_MF_UW,
  parameter int VC_UW = DEF_VC_UW,
  parameter int D_UW  = DEF_D_UW
);
  logic             init;
  logic [MF_UW-1:0] umbral_MF_in;
  logic [VC_UW-1:0] umbral_VC0_in;
  logic [VC_UW-1:0] umbral_VC1_in;
  logic [D_UW-1:0]  umbral_D0_in;
  logic [D_UW-1:0]  umbral_D1_in;
  logic [4:0]       fifo_empty;
  logic [4:0]       fifo_error;
  logic [3:0]       almost_full;
  logic [MF_UW-1:0] umbral_MF;
  logic [VC_UW-1:0] umbral_VC0;
  logic [VC_UW-1:0] umbral_VC1;
  logic [D_UW-1:0]  umbral_D0;
  logic [D_UW-1:0]  umbral_D1;
  logic             pop_MF;
  logic             pop_VC0;
  logic             pop_VC1;
  logic             active_out;
  logic             idle_out;
  logic             error_out;
  logic [4:0]       error_src;
  modport master (
    input  init, umbral_MF_in, umbral_VC0_in, umbral_VC1_in, umbral_D0_in, umbral_D1_in,
           fifo_empty, fifo_error, almost_full,
    output umbral_MF, umbral_VC0, umbral_VC1, umbral_D0, umbral_D1,
           pop_MF, pop_VC0, pop_VC1, active_out, idle_out, error_out, error_src
  );
  modport slave (
    output init, umbral_MF_in, umbral_VC0_in, umbral_VC1_in, umbral_D0_in, umbral_D1_in,
           fifo_empty, fifo_error, almost_full,
    input  umbral_MF, umbral_VC0, umbral_VC1, umbral_D0, umbral_D1,
           pop_MF, pop_VC0, pop_VC1, active_out, idle_out, error_out, error_src
  );
endinterface

// File: rtl/pcie_vc_arbiter.sv
// pcie_vc_arbiter: pop arbitration for MF and VC0/VC1 with downstream backpressure
module pcie_vc_arbiter
  import pcie_logica_master_pkg::*;
(
  input  logic       en,
  input  logic [4:0] fifo_empty,
  input  logic [3:0] almost_full,
  output logic       pop_mf,
  output logic       pop_vc0,
  output logic       pop_vc1
);
  logic mf_room, d_room;
  // almost_full has no MF bit, so its index is the FIFO index minus one
  assign mf_room = !almost_full[VC0_IDX-1] && !almost_full[VC1_IDX-1];
  assign d_room  = !almost_full[D0_IDX-1] && !almost_full[D1_IDX-1];
  assign pop_mf  = en && !fifo_empty[MF_IDX] && mf_room;
  assign pop_vc0 = en && !fifo_empty[VC0_IDX] && d_room;
  assign pop_vc1 = en && !fifo_empty[VC1_IDX] && d_room && !pop_vc0;
endmodule

// File: rtl/pcie_logica_master.sv
// pcie_logica_master: datapath state sequencing, threshold registers and pop arbitration
module pcie_logica_master
  import pcie_logica_master_pkg::*;
#(
  parameter int MF_UW = DEF_MF_UW,
  parameter int VC_UW = DEF_VC_UW,
  parameter int D_UW  = DEF_D_UW
) (
  input logic clk,
  input logic reset_L,
  pcie_logica_master_if.master bus
);
  logic [2:0]       state, state_nxt;
  logic [MF_UW-1:0] umbral_mf;
  logic [VC_UW-1:0] umbral_vc0, umbral_vc1;
  logic [D_UW-1:0]  umbral_d0, umbral_d1;
  logic [4:0]       error_src;
  logic             err, all_empty, run;
  assign err       = |bus.fifo_error;
  assign all_empty = &bus.fifo_empty;
  assign run       = state == S_IDLE || state == S_ACTIVE;
  always_comb begin
    state_nxt = S_RESET;
    case (state)
      S_RESET:  state_nxt = S_INIT;
      S_INIT:   state_nxt = bus.init ? S_INIT : S_IDLE;
      S_IDLE:   state_nxt = err ? S_ERROR : bus.init ? S_INIT : all_empty ? S_IDLE : S_ACTIVE;
      S_ACTIVE: state_nxt = err ? S_ERROR : bus.init ? S_INIT : all_empty ? S_IDLE : S_ACTIVE;
      S_ERROR:  state_nxt = bus.init ? S_INIT : S_ERROR;
      default:  state_nxt = S_RESET;
    endcase
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= S_RESET;
      umbral_mf  <= '0;
      umbral_vc0 <= '0;
      umbral_vc1 <= '0;
      umbral_d0  <= '0;
      umbral_d1  <= '0;
      error_src  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) begin
        umbral_mf  <= bus.umbral_MF_in;
        umbral_vc0 <= bus.umbral_VC0_in;
        umbral_vc1 <= bus.umbral_VC1_in;
        umbral_d0  <= bus.umbral_D0_in;
        umbral_d1  <= bus.umbral_D1_in;
      end
      error_src <= state == S_INIT ? 5'b0 : (run && err) ? bus.fifo_error : error_src;
    end
  end
  assign bus.umbral_MF  = umbral_mf;
  assign bus.umbral_VC0 = umbral_vc0;
  assign bus.umbral_VC1 = umbral_vc1;
  assign bus.umbral_D0  = umbral_d0;
  assign bus.umbral_D1  = umbral_d1;
  assign bus.error_src  = error_src;
  assign bus.active_out = state == S_ACTIVE;
  assign bus.idle_out   = state == S_IDLE;
  assign bus.error_out  = state == S_ERROR;
  pcie_vc_arbiter u_arb (
    .en          (state == S_ACTIVE),
    .fifo_empty  (bus.fifo_empty),
    .almost_full (bus.almost_full),
    .pop_mf      (bus.pop_MF),
    .pop_vc0     (bus.pop_VC0),
    .pop_vc1     (bus.pop_VC1)
  );
endmodule

// File: tb/tb_pcie_logica_master.sv
// tb_pcie_logica_master: directed vectors against hand-computed expectations
module tb_pcie_logica_master;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  pcie_logica_master_if bus ();
  pcie_logica_master dut (.clk(clk), .reset_L(reset_L), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic status(input string tag, input logic [2:0] exp);
    check({tag, "_status"}, {29'b0, bus.error_out, bus.active_out, bus.idle_out}, {29'b0, exp});
  endtask
  function automatic logic [2:0] pops();
    return {bus.pop_VC1, bus.pop_VC0, bus.pop_MF};
  endfunction
  initial begin
    bus.init = 1'b0;
    bus.umbral_MF_in = '0;
    bus.umbral_VC0_in = '0;
    bus.umbral_VC1_in = '0;
    bus.umbral_D0_in = '0;
    bus.umbral_D1_in = '0;
    bus.fifo_empty = 5'b11111;
    bus.fifo_error = '0;
    bus.almost_full = '0;
    step();
    step();
    status("rst", 3'b000);
    check("rst_umbral", {bus.umbral_MF, bus.umbral_VC0, bus.umbral_VC1, bus.umbral_D0, bus.umbral_D1}, 0);
    check("rst_err_src", bus.error_src, 0);
    reset_L = 1'b1;
    bus.init = 1'b1;
    bus.umbral_MF_in = 2'd3;
    bus.umbral_VC0_in = 4'hA;
    bus.umbral_VC1_in = 4'h5;
    bus.umbral_D0_in = 2'd2;
    bus.umbral_D1_in = 2'd1;
    step();
    check("init_enter_vc0", bus.umbral_VC0, 4'h0);
    status("init_enter", 3'b000);
    step();
    check("init_vc0", bus.umbral_VC0, 4'hA);
    check("init_all", {bus.umbral_MF, bus.umbral_VC0, bus.umbral_VC1, bus.umbral_D0, bus.umbral_D1}, 14'b11_1010_0101_10_01);
    status("init", 3'b000);
    bus.init = 1'b0;
    bus.fifo_empty = 5'b11110;
    step();
    status("idle", 3'b001);
    check("idle_pops", pops(), 3'b000);
    bus.umbral_VC0_in = 4'h3;
    bus.umbral_MF_in = 2'd0;
    step();
    status("active", 3'b010);
    check("active_pop_mf", pops(), 3'b001);
    check("hold_vc0", bus.umbral_VC0, 4'hA);
    bus.almost_full = 4'b0001;
    #1 check("bp_mf", pops(), 3'b000);
    bus.almost_full = 4'b0000;
    bus.fifo_empty = 5'b11000;
    #1 check("prio_vc0", pops(), 3'b011);
    bus.fifo_empty = 5'b11010;
    #1 check("vc1_alone", pops(), 3'b101);
    bus.almost_full = 4'b1000;
    #1 check("bp_vc", pops(), 3'b001);
    bus.almost_full = 4'b0000;
    step();
    status("active_hold", 3'b010);
    bus.fifo_empty = 5'b11111;
    step();
    status("drain", 3'b001);
    check("drain_pops", pops(), 3'b000);
    bus.fifo_empty = 5'b11110;
    step();
    status("reactive", 3'b010);
    bus.fifo_error = 5'b00100;
    step();
    status("error", 3'b100);
    check("err_src", bus.error_src, 5'b00100);
    bus.fifo_error = 5'b00000;
    step();
    status("err_sticky", 3'b100);
    check("err_src_hold", bus.error_src, 5'b00100);
    check("err_pops", pops(), 3'b000);
    bus.init = 1'b1;
    step();
    status("err_exit", 3'b000);
    step();
    check("reinit_err_src", bus.error_src, 5'b00000);
    check("reinit_vc0", bus.umbral_VC0, 4'h3);
    check("reinit_mf", bus.umbral_MF, 2'd0);
    bus.init = 1'b0;
    step();
    status("idle2", 3'b001);
    bus.fifo_error = 5'b00001;
    step();
    status("idle_err", 3'b100);
    check("idle_err_src", bus.error_src, 5'b00001);
    bus.init = 1'b0;
    bus.fifo_error = 5'b00000;
    step();
    bus.init = 1'b1;
    step();
    bus.init = 1'b0;
    step();
    step();
    status("active2", 3'b010);
    bus.fifo_error = 5'b01000;
    bus.init = 1'b1;
    step();
    status("err_beats_init", 3'b100);
    check("err_beats_init_src", bus.error_src, 5'b01000);
    bus.fifo_error = 5'b00000;
    step();
    status("init_after_err", 3'b000);
    bus.init = 1'b0;
    step();
    step();
    status("active3", 3'b010);
    #2 reset_L = 1'b0;
    #1;
    status("async_rst", 3'b000);
    check("async_rst_pops", pops(), 3'b000);
    check("async_rst_umbral", {bus.umbral_MF, bus.umbral_VC0, bus.umbral_VC1, bus.umbral_D0, bus.umbral_D1}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
